// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM handshake state and arbiter FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DREQ  = 3'd1,
        IREQ  = 3'd2,
        DRESP = 3'd3,
        IRESP = 3'd4
    } arb_state_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// RAM wait-cycle counter for the memory arbiter; only present when MEM_TIMEOUT_EN is defined.
// expired_o fires during the TIMEOUT_CYC-th consecutive enabled cycle.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_counter #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && (count_q == LIMIT);

endmodule
`endif

// File: rtl/mem_request_arbiter.sv
// Single-port RAM arbiter for instruction/data requests; data wins ties, one-cycle hit pulses.
// Optional MEM_TIMEOUT_EN adds a bounded RAM wait with a sticky mem_err flag.
module mem_request_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      ihit,
    output word_t     iload,
    output logic      dhit,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      mem_err
);

    arb_state_t state_q, state_d;
    word_t      addr_q, addr_d;
    word_t      store_q, store_d;
    word_t      load_q, load_d;
    logic       op_wr_q, op_wr_d;
    logic       in_req;
    logic       timeout_abort;

    assign in_req = (state_q == DREQ) || (state_q == IREQ);

`ifdef MEM_TIMEOUT_EN
    logic timeout_expired;
    logic mem_err_q;

    mem_timeout_counter #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clear_i  (!in_req),
        .enable_i (in_req),
        .expired_o(timeout_expired)
    );

    // A completing access in the expiry cycle wins over the abort.
    assign timeout_abort = timeout_expired && (ramstate != ACCESS);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_err_q <= 1'b0;
        end else if (timeout_abort) begin
            mem_err_q <= 1'b1;
        end
    end

    assign mem_err = mem_err_q;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout_abort = 1'b0;
    assign mem_err       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        store_d = store_q;
        load_d  = load_q;
        op_wr_d = op_wr_q;
        case (state_q)
            IDLE: begin
                if (dREN || dWEN) begin
                    addr_d  = daddr;
                    store_d = dstore;
                    op_wr_d = dWEN;
                    state_d = DREQ;
                end else if (iREN) begin
                    addr_d  = iaddr;
                    state_d = IREQ;
                end
            end
            DREQ, IREQ: begin
                if (ramstate == ACCESS) begin
                    load_d  = ramload;
                    state_d = (state_q == DREQ) ? DRESP : IRESP;
                end else if (timeout_abort) begin
                    state_d = IDLE;
                end
            end
            DRESP, IRESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            store_q <= '0;
            load_q  <= '0;
            op_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            load_q  <= load_d;
            op_wr_q <= op_wr_d;
        end
    end

    // RAM side is decoded purely from registered state so reset drops it immediately.
    assign ramWEN   = (state_q == DREQ) && op_wr_q;
    assign ramREN   = ((state_q == DREQ) && !op_wr_q) || (state_q == IREQ);
    assign ramaddr  = in_req ? addr_q : '0;
    assign ramstore = ramWEN ? store_q : '0;

    assign ihit  = (state_q == IRESP);
    assign dhit  = (state_q == DRESP);
    assign iload = ihit ? load_q : '0;
    assign dload = dhit ? load_q : '0;

endmodule
